// File: rtl/window_5x5_gen_pkg.sv
// Shared pixel type and window geometry for the 5x5 window generator.
package win_pkg;
  typedef logic [15:0] pixel_t;

  localparam int WIN_DIM    = 5;
  localparam int WIN_PIXELS = 25;
  localparam int WIN_CENTRE = 12;
endpackage

// File: rtl/window_5x5_gen_if.sv
// Pixel stream in, 5x5 window plus centre coordinates out.
interface window_5x5_gen_if
  import win_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  pixel_t         pixel_in;
  logic           pixel_valid;
  logic           frame_start;
  pixel_t         window5x5 [WIN_PIXELS];
  logic           window_valid;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  window5x5, window_valid, centre_x, centre_y
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output window5x5, window_valid, centre_x, centre_y
  );
endinterface

// File: rtl/window_5x5_gen_line_buffer.sv
// One image row of pixel storage with a registered read port; contents are not reset.
module line_buffer
  import win_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output pixel_t        rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  pixel_t        wr_data_i
);
  pixel_t mem_q [DEPTH];

  // A read and a write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end
endmodule

// File: rtl/window_5x5_gen.sv
// Raster RGB565 stream to sliding 5x5 window: counters, sync, four cascaded
// line buffers (stage 1) and the 5x5 column shift array (stage 2).
module window_5x5_gen
  import win_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9
) (
  input logic             clk,
  input logic             rst_n,
  window_5x5_gen_if.slave bus
);
  localparam int             LB_AW  = $clog2(IMG_WIDTH);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic           sync_q, accept;
  logic [X_W-1:0] x_q, x_d, curX;
  logic [Y_W-1:0] y_q, y_d, curY;

  logic           s1Valid_q, s1Win_q;
  logic [X_W-1:0] s1X_q;
  logic [Y_W-1:0] s1Y_q;
  pixel_t         s1Pixel_q;

  pixel_t lbRd [4];
  pixel_t lbWr [4];
  pixel_t column [WIN_DIM];

  pixel_t         win_q [WIN_PIXELS];
  logic           valid_q;
  logic [X_W-1:0] centreX_q;
  logic [Y_W-1:0] centreY_q;

  // A frame_start beat is always taken as (0,0), even before the first sync.
  always_comb begin
    accept = bus.pixel_valid & (bus.frame_start | sync_q);
    curX   = bus.frame_start ? '0 : x_q;
    curY   = bus.frame_start ? '0 : y_q;
    x_d    = curX + X_W'(1);
    y_d    = curY;
    if (curX == X_LAST) begin
      x_d = '0;
      y_d = (curY == Y_LAST) ? '0 : curY + Y_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      s1Valid_q <= 1'b0;
      s1Win_q   <= 1'b0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
      s1Pixel_q <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        sync_q    <= 1'b1;
        x_q       <= x_d;
        y_q       <= y_d;
        s1Win_q   <= (curX >= X_W'(4)) && (curY >= Y_W'(4));
        s1X_q     <= curX;
        s1Y_q     <= curY;
        s1Pixel_q <= bus.pixel_in;
      end
    end
  end

  // Cascade writes land one cycle after the read, once the older row is out.
  assign lbWr[0] = s1Pixel_q;
  for (genvar k = 1; k < 4; k++) begin : g_cascade
    assign lbWr[k] = lbRd[k-1];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lb
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(LB_AW)) u_lb (
      .clk       (clk),
      .rd_en_i   (accept),
      .rd_addr_i (curX[LB_AW-1:0]),
      .rd_data_o (lbRd[k]),
      .wr_en_i   (s1Valid_q),
      .wr_addr_i (s1X_q[LB_AW-1:0]),
      .wr_data_i (lbWr[k])
    );
  end

  always_comb begin
    for (int r = 0; r < WIN_DIM - 1; r++) column[r] = lbRd[WIN_DIM-2-r];
    column[WIN_DIM-1] = s1Pixel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_PIXELS; i++) win_q[i] <= '0;
      valid_q   <= 1'b0;
      centreX_q <= '0;
      centreY_q <= '0;
    end else begin
      valid_q <= s1Valid_q & s1Win_q;
      if (s1Valid_q) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          for (int c = 0; c < WIN_DIM - 1; c++) win_q[r*WIN_DIM+c] <= win_q[r*WIN_DIM+c+1];
          win_q[r*WIN_DIM+WIN_DIM-1] <= column[r];
        end
        if (s1Win_q) begin
          centreX_q <= s1X_q - X_W'(2);
          centreY_q <= s1Y_q - Y_W'(2);
        end
      end
    end
  end

  assign bus.window5x5    = win_q;
  assign bus.window_valid = valid_q;
  assign bus.centre_x     = centreX_q;
  assign bus.centre_y     = centreY_q;
endmodule
